inv_lift53: RTL and testbench

INV_LIFT53 -- requirements
Module: inv_lift53

---
 rtl/inv_lift53.sv | 108 ++++++++++
 tb/tb_inv_lift53.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_lift53.sv
// Inverse 5/3 lifting, one (low, high) coefficient pair per cycle, with symmetric row edges.
// Define INV_LIFT53_SAT_EN to saturate the outputs; otherwise they wrap to W bits.
module inv_lift53 #(
   parameter int W      = 16,
   parameter int NPAIRS = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] s_in,
   input  logic [W-1:0] d_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_even,
   output logic [W-1:0] out_odd,
   output logic         out_last
);
   localparam int AW = W + 3;
   localparam int CW = $clog2(NPAIRS);
   localparam logic [CW-1:0] LASTC = CW'(NPAIRS - 1);
   localparam logic signed [AW-1:0] TWO = AW'(2);

   typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic signed [AW-1:0]  e_q;
   logic [W-1:0]          d_q;

   logic signed [AW-1:0]  s_x, d_x, dq_x, dp_x, sum_d, e_n, sum_e, o_n, o_last;
   logic                  slot_free, acc;

   assign s_x  = {{3{s_in[W-1]}}, s_in};
   assign d_x  = {{3{d_in[W-1]}}, d_in};
   assign dq_x = {{3{d_q[W-1]}}, d_q};
   // Pair 0 has no left neighbour, so d[-1] mirrors to d[0].
   assign dp_x   = (state == HOLD) ? dq_x : d_x;
   assign sum_d  = dp_x + d_x + TWO;
   assign e_n    = s_x - (sum_d >>> 2);
   assign sum_e  = e_q + e_n;
   assign o_n    = dq_x + (sum_e >>> 1);
   // Right edge: e[N] = e[N-1], so floor((e+e)/2) collapses to e.
   assign o_last = dq_x + e_q;

   assign slot_free = !out_valid || out_ready;
   assign in_ready  = (state == IDLE) || ((state == HOLD) && slot_free);
   assign acc       = in_valid && in_ready;

`ifdef INV_LIFT53_SAT_EN
   localparam logic signed [AW-1:0] VMAX = AW'((2 ** (W - 1)) - 1);
   localparam logic signed [AW-1:0] VMIN = AW'(-(2 ** (W - 1)));
   function automatic logic [W-1:0] fit(input logic signed [AW-1:0] v);
      if (v > VMAX) return VMAX[W-1:0];
      if (v < VMIN) return VMIN[W-1:0];
      return v[W-1:0];
   endfunction
`else
   function automatic logic [W-1:0] fit(input logic signed [AW-1:0] v);
      return v[W-1:0];
   endfunction
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         e_q       <= '0;
         d_q       <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_even  <= '0;
         out_odd   <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (state)
            IDLE: if (acc) begin
               e_q   <= e_n;
               d_q   <= d_in;
               cnt   <= CW'(1);
               state <= HOLD;
            end
            HOLD: if (acc) begin
               out_even  <= fit(e_q);
               out_odd   <= fit(o_n);
               out_valid <= 1'b1;
               out_last  <= 1'b0;
               e_q       <= e_n;
               d_q       <= d_in;
               cnt       <= cnt + 1'b1;
               if (cnt == LASTC) state <= FLUSH;
            end
            FLUSH: if (slot_free) begin
               out_even  <= fit(e_q);
               out_odd   <= fit(o_last);
               out_valid <= 1'b1;
               out_last  <= 1'b1;
               cnt       <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_lift53.sv
// Scoreboard bench for inv_lift53: a reference model pushes expected pairs, a monitor pops them.
module tb_inv_lift53;
   localparam int W  = 16;
   localparam int NP = 4;

   logic         clk = 1'b0, rst_n = 1'b1;
   logic         in_valid = 1'b0, in_ready;
   logic [W-1:0] s_in = '0, d_in = '0;
   logic         out_valid, out_ready = 1'b1, out_last;
   logic [W-1:0] out_even, out_odd;

   inv_lift53 #(.W(W), .NPAIRS(NP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .s_in(s_in), .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_even(out_even), .out_odd(out_odd), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct {int ev; int od; bit last;} exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0, stalls = 0;
   int rs[NP], rd[NP];
   bit manual = 0, rnd_ready = 0;

   function automatic int fdiv(int a, int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic int fit(int v);
`ifdef INV_LIFT53_SAT_EN
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
`else
      return ((v + 32768) & 65535) - 32768;
`endif
   endfunction

   // Expected outputs once k pairs of the current row (rs/rd) have been accepted.
   function automatic void push_row(int k);
      int e[NP+1];
      int nout;
      exp_t x;
      for (int n = 0; n < NP; n++)
         e[n] = rs[n] - fdiv(rd[(n == 0) ? 0 : n - 1] + rd[n] + 2, 4);
      e[NP] = e[NP-1];
      nout = (k >= NP) ? NP : k - 1;
      for (int n = 0; n < nout; n++) begin
         x.ev = fit(e[n]);
         x.od = fit(rd[n] + fdiv(e[n] + e[n+1], 2));
         x.last = (n == NP - 1);
         sb.push_back(x);
      end
   endfunction

   function automatic void rand_row();
      for (int n = 0; n < NP; n++) begin
         rs[n] = int'($urandom_range(0, 65535)) - 32768;
         rd[n] = int'($urandom_range(0, 65535)) - 32768;
      end
   endfunction

   initial forever begin
      @(posedge clk); #1;
      if (!manual) out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   always @(negedge clk) begin : mon
      exp_t x;
      if (in_valid && !in_ready) stalls++;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_pair: unexpected output even=%0d odd=%0d", $signed(out_even), $signed(out_odd));
         end else begin
            x = sb.pop_front();
            if (int'($signed(out_even)) !== x.ev || int'($signed(out_odd)) !== x.od || out_last !== x.last) begin
               errors++;
               $display("FAIL out_pair: got (%0d,%0d,last=%0b) want (%0d,%0d,last=%0b)",
                        $signed(out_even), $signed(out_odd), out_last, x.ev, x.od, x.last);
            end
         end
      end
   end

   task automatic send_pair(int s, int d);
      int t = 0;
      in_valid = 1'b1; s_in = W'(s); d_in = W'(d);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 200) begin
            errors++; checks++;
            $display("FAIL send_timeout: in_ready=%0b want 1 within 200 cycles", in_ready);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_row(int k);
      for (int n = 0; n < k; n++) send_pair(rs[n], rd[n]);
   endtask

   task automatic drain(string name);
      int t = 0;
      while (sb.size() != 0 && t < 400) begin @(posedge clk); t++; end
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d pairs outstanding, want 0", name, sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_last, out_even, out_odd} !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: valid=%0b last=%0b even=%0d odd=%0d rdy=%0b want 0/0/0/0/1",
                  out_valid, out_last, out_even, out_odd, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %0b want 1", in_ready);
      end
   endtask

   task automatic test_const_row();
      for (int n = 0; n < NP; n++) begin rs[n] = 100; rd[n] = 0; end
      push_row(NP);
      send_row(NP);
      drain("const_row");
   endtask

   task automatic test_pairs();
      rs = '{80, 120, 60, -50};
      rd = '{4, -4, 10, -7};
      push_row(NP);
      send_pair(rs[0], rd[0]);
      send_pair(rs[1], rd[1]);
      checks++;
      if (out_valid !== 1'b1 || $signed(out_even) !== 16'sd78 || $signed(out_odd) !== 16'sd103) begin
         errors++;
         $display("FAIL first_pair: got v=%0b (%0d,%0d) want v=1 (78,103)", out_valid, $signed(out_even), $signed(out_odd));
      end
      send_pair(rs[2], rd[2]);
      send_pair(rs[3], rd[3]);
      drain("pairs");
   endtask

   task automatic test_stall();
      int blocked = 0;
      rs = '{10, -20, 300, 7};
      rd = '{-3, 9, 1, -40};
      push_row(NP);
      send_pair(rs[0], rd[0]);
      manual = 1; out_ready = 1'b0;
      send_pair(rs[1], rd[1]);
      in_valid = 1'b1; s_in = W'(rs[2]); d_in = W'(rd[2]);
      repeat (5) begin
         @(negedge clk);
         if (!in_ready) blocked++;
         @(posedge clk); #1;
      end
      checks++;
      if (blocked != 5) begin
         errors++;
         $display("FAIL stall_ready: in_ready low for %0d cycles, want 5", blocked);
      end
      out_ready = 1'b1; manual = 0;
      send_pair(rs[2], rd[2]);
      send_pair(rs[3], rd[3]);
      drain("stall");
   endtask

   task automatic test_sat();
      for (int n = 0; n < NP; n++) begin rs[n] = 32767; rd[n] = -32768; end
      push_row(NP);
      send_pair(rs[0], rd[0]);
      send_pair(rs[1], rd[1]);
      checks++;
`ifdef INV_LIFT53_SAT_EN
      if ($signed(out_even) !== 16'sd32767) begin
         errors++;
         $display("FAIL sat_even: got %0d want 32767", $signed(out_even));
      end
`else
      if ($signed(out_even) !== -16'sd16385) begin
         errors++;
         $display("FAIL wrap_even: got %0d want -16385", $signed(out_even));
      end
`endif
      send_pair(rs[2], rd[2]);
      send_pair(rs[3], rd[3]);
      drain("sat");
   endtask

   task automatic test_reset_mid();
      rand_row();
      push_row(3);
      send_row(3);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL mid_partial: %0d pairs outstanding, want 0", sb.size());
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_last, out_even, out_odd} !== '0) begin
         errors++;
         $display("FAIL mid_reset_clear: valid=%0b last=%0b even=%0d odd=%0d want all 0",
                  out_valid, out_last, out_even, out_odd);
      end
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      rand_row();
      push_row(NP);
      send_row(NP);
      drain("reset_mid");
   endtask

   task automatic test_back_to_back();
      stalls = 0;
      rand_row(); push_row(NP); send_row(NP);
      rand_row(); push_row(NP); send_row(NP);
      checks++;
      if (stalls != 1) begin
         errors++;
         $display("FAIL b2b_stalls: got %0d stall cycles want 1", stalls);
      end
      drain("back_to_back");
   endtask

   task automatic test_random();
      rnd_ready = 1;
      repeat (4) begin rand_row(); push_row(NP); send_row(NP); end
      drain("random");
      rnd_ready = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_const_row();
      test_pairs();
      test_stall();
      test_sat();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
